scff_chain_checker: RTL and testbench

// Self-checking scan-chain (scff) integrity tester for the FPGA fabric configuration chains.

---
 rtl/scff_chain_checker.sv | 210 +++++++++++++++++++++
 tb/tb_scff_chain_checker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scff_chain_checker.sv
// Scan-chain integrity checker: fills NUM_CHAINS chains with a selectable pattern,
// then compares every tail against a delayed reference copy and reports mismatches.
module scff_chain_checker #(
    parameter int          CHAIN_LEN  = 1024,
    parameter int          NUM_CHAINS = 1,
    parameter int          CNT_W      = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         IDX_W      = $clog2(CHAIN_LEN),
    localparam int         CH_W       = $clog2((NUM_CHAINS > 2) ? NUM_CHAINS : 2)
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    output logic [NUM_CHAINS-1:0] sc_head,
    input  logic [NUM_CHAINS-1:0] sc_tail,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [IDX_W-1:0]      first_err_idx,
    output logic [CH_W-1:0]       first_err_chan
);
    localparam int K_W  = IDX_W + 1;
    localparam int PC_W = $clog2(NUM_CHAINS + 1);
    localparam int S_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [K_W-1:0]   FILL_LAST  = K_W'(CHAIN_LEN - 1);
    localparam logic [K_W-1:0]   CHECK_LAST = K_W'(2 * CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    function automatic logic [NUM_CHAINS-1:0] alt_mask();
        logic [NUM_CHAINS-1:0] m;
        for (int c = 0; c < NUM_CHAINS; c++) m[c] = ((c % 2) == 1);
        return m;
    endfunction

    // Odd chains carry the complemented pattern so shorts/swaps between neighbours show up.
    localparam logic [NUM_CHAINS-1:0] CHAN_MASK = alt_mask();

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic pattern_bit(input logic [1:0] md, input logic k0,
                                         input logic k1, input logic l0);
        case (md)
            2'd0:    return k0;
            2'd1:    return k1;
            2'd2:    return l0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CHAINS-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CHAINS; i++) cnt = cnt + PC_W'(v[i]);
        return cnt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0] b);
        logic [S_W-1:0] sum;
        sum = S_W'(a) + S_W'(b);
        if (sum > S_W'(CNT_MAX)) return CNT_MAX;
        return sum[CNT_W-1:0];
    endfunction

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CHAINS-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CHAINS - 1; i >= 0; i--) if (v[i]) idx = CH_W'(i);
        return idx;
    endfunction

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [IDX_W-1:0]        ref_k_q, ref_k_d;
    logic [15:0]             ref_lfsr_q, ref_lfsr_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_W-1:0]        err_count_q, err_count_d;
    logic [IDX_W-1:0]        first_idx_q, first_idx_d;
    logic [CH_W-1:0]         first_chan_q, first_chan_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [NUM_CHAINS-1:0]   sc_head_q, sc_head_d;
    logic [NUM_CHAINS-1:0]   exp_vec, mism;
    logic                    ref_k1;

    if (IDX_W > 1) begin : g_ref_k1
        assign ref_k1 = ref_k_q[1];
    end else begin : g_ref_k1_zero
        assign ref_k1 = 1'b0;
    end

    // Reference generator replays the pattern from index 0 while CHECK runs.
    assign exp_vec = {NUM_CHAINS{pattern_bit(mode_q, ref_k_q[0], ref_k1, ref_lfsr_q[0])}} ^ CHAN_MASK;
    assign mism    = sc_tail ^ exp_vec;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        lfsr_d       = lfsr_q;
        ref_k_d      = ref_k_q;
        ref_lfsr_d   = ref_lfsr_q;
        mode_d       = mode_q;
        err_count_d  = err_count_q;
        first_idx_d  = first_idx_q;
        first_chan_d = first_chan_q;
        done_d       = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = FILL;
                    k_d          = '0;
                    lfsr_d       = LFSR_SEED;
                    mode_d       = mode;
                    err_count_d  = '0;
                    first_idx_d  = '0;
                    first_chan_d = '0;
                    done_d       = 1'b0;
                end
            end
            FILL: begin
                k_d    = k_q + K_W'(1);
                lfsr_d = lfsr_step(lfsr_q);
                if (k_q == FILL_LAST) begin
                    state_d    = CHECK;
                    ref_k_d    = '0;
                    ref_lfsr_d = LFSR_SEED;
                end
            end
            CHECK: begin
                k_d         = k_q + K_W'(1);
                lfsr_d      = lfsr_step(lfsr_q);
                ref_k_d     = ref_k_q + IDX_W'(1);
                ref_lfsr_d  = lfsr_step(ref_lfsr_q);
                err_count_d = sat_add(err_count_q, popcount(mism));
                // A zero count means no mismatch has been seen yet in this run.
                if ((mism != '0) && (err_count_q == '0)) begin
                    first_idx_d  = ref_k_q;
                    first_chan_d = lowest_set(mism);
                end
                if (k_q == CHECK_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            err_count_d  = '0;
            first_idx_d  = '0;
            first_chan_d = '0;
            done_d       = 1'b0;
        end

        busy_d    = (state_d == FILL) || (state_d == CHECK);
        sc_head_d = busy_d ? ({NUM_CHAINS{pattern_bit(mode_d, k_d[0], k_d[1], lfsr_d[0])}} ^ CHAN_MASK)
                           : '0;
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            lfsr_q       <= LFSR_SEED;
            ref_k_q      <= '0;
            ref_lfsr_q   <= LFSR_SEED;
            mode_q       <= 2'd0;
            err_count_q  <= '0;
            first_idx_q  <= '0;
            first_chan_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            sc_head_q    <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            lfsr_q       <= lfsr_d;
            ref_k_q      <= ref_k_d;
            ref_lfsr_q   <= ref_lfsr_d;
            mode_q       <= mode_d;
            err_count_q  <= err_count_d;
            first_idx_q  <= first_idx_d;
            first_chan_q <= first_chan_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            sc_head_q    <= sc_head_d;
        end
    end

    assign sc_head        = sc_head_q;
    assign shift_en       = busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_count_q == '0);
    assign err_count      = err_count_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_chan = first_chan_q;

endmodule

// File: tb/tb_scff_chain_checker.sv
// Bench for scff_chain_checker: behavioural scan chains with injectable faults and an
// elapsed-cycle reference model checked every cycle, plus hand-computed expectations.
module tb_scff_chain_checker;
    localparam int L     = 8;
    localparam int NC    = 2;
    localparam int IDX_W = 3;
    localparam int CH_W  = 1;

    logic             prog_clk = 1'b0;
    logic             prog_reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [NC-1:0]    sc_head, sc_tail;
    logic             shift_en, busy, done, pass;
    logic [15:0]      err_count;
    logic [IDX_W-1:0] first_err_idx;
    logic [CH_W-1:0]  first_err_chan;

    logic             start_s = 1'b0;
    logic [NC-1:0]    sc_head_s;
    logic             shift_en_s, busy_s, done_s, pass_s;
    logic [2:0]       err_count_s;
    logic [IDX_W-1:0] fidx_s;
    logic [CH_W-1:0]  fchan_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 prog_clk = ~prog_clk;

    scff_chain_checker #(.CHAIN_LEN(L), .NUM_CHAINS(NC), .CNT_W(16), .LFSR_SEED(16'hACE1)) u_dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort), .mode(mode),
        .sc_head(sc_head), .sc_tail(sc_tail), .shift_en(shift_en), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_chan(first_err_chan));

    // Narrow-counter instance whose chains are stuck-at-1 at the tails.
    scff_chain_checker #(.CHAIN_LEN(L), .NUM_CHAINS(NC), .CNT_W(3), .LFSR_SEED(16'hACE1)) u_dut_sat (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_s), .abort(1'b0), .mode(2'd0),
        .sc_head(sc_head_s), .sc_tail(2'b11), .shift_en(shift_en_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .err_count(err_count_s), .first_err_idx(fidx_s), .first_err_chan(fchan_s));

    // Behavioural scan chains with optional stuck flop, short length and swapped tails.
    logic [L-1:0] chain [NC] = '{default: '0};
    logic [L-1:0] eff_v [NC];
    int           chain_len = L;
    logic         stuck_en = 1'b0;
    int           stuck_chan = 0;
    int           stuck_flop = 0;
    logic         stuck_val = 1'b0;
    logic         swap = 1'b0;
    logic         t0, t1;

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            eff_v[c] = chain[c];
            if (stuck_en && stuck_chan == c) eff_v[c][stuck_flop] = stuck_val;
        end
        t0 = eff_v[0][chain_len-1];
        t1 = eff_v[1][chain_len-1];
        sc_tail = swap ? {t0, t1} : {t1, t0};
    end

    always @(posedge prog_clk)
        if (shift_en)
            for (int c = 0; c < NC; c++) chain[c] <= {eff_v[c][L-2:0], sc_head[c]};

    function automatic int pat(input logic [1:0] md, input int k);
        int s;
        s = 'hACE1;
        case (md)
            2'd0: return k & 1;
            2'd1: return (k >> 1) & 1;
            2'd2: begin
                for (int i = 0; i < k; i++)
                    s = (s >> 1) | (((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1) << 15);
                return s & 1;
            end
            default: return 1;
        endcase
    endfunction

    function automatic logic [NC-1:0] mism(input logic [NC-1:0] tails, input logic [1:0] md,
                                           input int j);
        logic [NC-1:0] m;
        for (int c = 0; c < NC; c++) m[c] = (int'(tails[c]) != (pat(md, j) ^ (c % 2)));
        return m;
    endfunction

    // Reference model: m_t counts edges since the accepted start (1..2L busy, 2L+1 done).
    int            m_t = 0;
    logic [1:0]    m_mode = 2'd0;
    int            m_err = 0;
    logic          m_seen = 1'b0;
    int            m_fidx = 0;
    int            m_fchan = 0;
    logic [NC-1:0] m_now;

    assign m_now = mism(sc_tail, m_mode, m_t - 1 - L);

    always @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset || abort) begin
            m_t <= 0; m_err <= 0; m_seen <= 1'b0; m_fidx <= 0; m_fchan <= 0;
            if (prog_reset) m_mode <= 2'd0;
        end else if (start && (m_t == 0 || m_t == 2 * L + 1)) begin
            m_t <= 1; m_mode <= mode; m_err <= 0; m_seen <= 1'b0; m_fidx <= 0; m_fchan <= 0;
        end else if (m_t >= 1 && m_t <= 2 * L) begin
            m_t <= m_t + 1;
            if (m_t - 1 >= L) begin
                m_err <= m_err + $countones(m_now);
                if (!m_seen && m_now != '0) begin
                    m_seen  <= 1'b1;
                    m_fidx  <= m_t - 1 - L;
                    m_fchan <= m_now[0] ? 0 : 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic          eb, ed;
        logic [NC-1:0] eh;
        eb = (m_t >= 1 && m_t <= 2 * L);
        ed = (m_t == 2 * L + 1);
        eh = '0;
        if (eb) for (int c = 0; c < NC; c++) eh[c] = ((pat(m_mode, m_t - 1) ^ (c % 2)) != 0);
        check("busy", busy, eb);
        check("shift_en", shift_en, eb);
        check("done", done, ed);
        check("pass", pass, ed && (m_err == 0));
        check("sc_head", sc_head, eh);
        check("err_count", err_count, (m_err > 65535) ? 65535 : m_err);
        check("first_err_idx", first_err_idx, m_fidx);
        check("first_err_chan", first_err_chan, m_fchan);
    endtask

    initial forever begin
        @(negedge prog_clk);
        check_cycle();
    end

    task automatic pulse_start();
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(inout int n);
        while (!done && n < 40) begin
            @(posedge prog_clk);
            #1 n++;
        end
        check("done_reached", done, 1'b1);
    endtask

    task automatic run(input logic [1:0] md, output int n);
        mode = md;
        pulse_start();
        n = 1;
        wait_done(n);
    endtask

    task automatic clear_faults();
        stuck_en = 1'b0; swap = 1'b0; chain_len = L;
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ab;
        repeat (3) @(posedge prog_clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_sc_head", sc_head, 2'b00);
        check("rst_err_count", err_count, 0);
        @(negedge prog_clk);
        prog_reset = 1'b0;

        // Ideal chains, alternating pattern.
        clear_faults();
        run(2'd0, n);
        check("t1_latency", n, 2 * L + 1);
        check("t1_err_count", err_count, 0);
        check("t1_pass", pass, 1'b1);

        // Chain 0 flop 3 stuck-at-0 with all-ones pattern.
        stuck_en = 1'b1; stuck_chan = 0; stuck_flop = 3; stuck_val = 1'b0;
        run(2'd3, n);
        check("t2_err_count", err_count, 8);
        check("t2_first_idx", first_err_idx, 0);
        check("t2_first_chan", first_err_chan, 0);
        check("t2_pass", pass, 1'b0);

        // One flop short, then full length, LFSR pattern.
        clear_faults();
        chain_len = L - 1;
        run(2'd2, n);
        check("t3_err_nonzero", err_count != 0, 1'b1);
        check("t3_pass_short", pass, 1'b0);
        chain_len = L;
        run(2'd2, n);
        check("t3_pass_full", pass, 1'b1);

        // Swapped tails, pairs pattern.
        swap = 1'b1;
        run(2'd1, n);
        check("t4_err_count", err_count, 16);
        check("t4_first_idx", first_err_idx, 0);
        check("t4_first_chan", first_err_chan, 0);
        clear_faults();

        // Asynchronous reset in FILL cycle 4.
        mode = 2'd0;
        pulse_start();
        repeat (4) @(posedge prog_clk);
        #2 prog_reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_shift_en", shift_en, 1'b0);
        check("t5_rst_sc_head", sc_head, 2'b00);
        check("t5_rst_done", done, 1'b0);
        @(negedge prog_clk);
        prog_reset = 1'b0;

        // Abort mid-CHECK with errors already counted.
        stuck_en = 1'b1; stuck_chan = 0; stuck_flop = 0; stuck_val = 1'b1;
        mode = 2'd0;
        pulse_start();
        repeat (12) @(posedge prog_clk);
        @(negedge prog_clk);
        abort = 1'b1;
        @(posedge prog_clk);
        #1 abort = 1'b0;
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_done", done, 1'b0);
        check("t5_abort_err", err_count, 0);
        repeat (4) @(posedge prog_clk);
        #1 check("t5_abort_done_later", done, 1'b0);
        clear_faults();

        // start while busy is ignored.
        mode = 2'd1;
        pulse_start();
        n = 1;
        repeat (3) begin
            @(posedge prog_clk);
            #1 n++;
        end
        mode = 2'd3;
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        n++;
        wait_done(n);
        check("t5_busy_start_latency", n, 2 * L + 1);
        check("t5_busy_start_pass", pass, 1'b1);

        // abort dominates start in DONE.
        @(negedge prog_clk);
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0; abort = 1'b0;
        check("t5_abort_dom_busy", busy, 1'b0);
        check("t5_abort_dom_done", done, 1'b0);

        // Saturating counter instance.
        for (int r = 0; r < 2; r++) begin
            @(negedge prog_clk);
            start_s = 1'b1;
            @(posedge prog_clk);
            #1 start_s = 1'b0;
            check("t6_restart_err", err_count_s, 0);
            check("t6_restart_busy", busy_s, 1'b1);
            n = 1;
            while (!done_s && n < 40) begin
                @(posedge prog_clk);
                #1 n++;
            end
            check("t6_latency", n, 2 * L + 1);
            check("t6_err_sat", err_count_s, 7);
            check("t6_pass", pass_s, 1'b0);
            check("t6_first_idx", fidx_s, 0);
            check("t6_first_chan", fchan_s, 0);
        end

        // Randomised runs checked by the per-cycle model.
        for (int r = 0; r < 16; r++) begin
            stuck_en   = 1'($urandom_range(0, 1));
            stuck_chan = $urandom_range(0, NC - 1);
            stuck_flop = $urandom_range(0, L - 1);
            stuck_val  = 1'($urandom_range(0, 1));
            swap       = ($urandom_range(0, 3) == 0);
            chain_len  = ($urandom_range(0, 3) == 0) ? L - 1 : L;
            ab         = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * L - 1) : 0;
            mode       = 2'($urandom_range(0, 3));
            pulse_start();
            n = 1;
            if (ab != 0) begin
                repeat (ab) @(posedge prog_clk);
                @(negedge prog_clk);
                abort = 1'b1;
                @(posedge prog_clk);
                #1 abort = 1'b0;
                repeat (2) @(posedge prog_clk);
            end else begin
                wait_done(n);
                check("rand_latency", n, 2 * L + 1);
            end
        end

        @(negedge prog_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
